// File: rtl/clm_round_ctrl.sv
// Purpose : round/stage sequencer for the CLM masked-AES core; it drives the stage
//           code and the round counter, and launches and collects the sbox and
//           key-expansion units.
// Latency : 85 cycles from the cycle drdy_i is sampled in IDLE to the drdy_o pulse,
//           with the default parameters and sbox done 3 and ke done 5 cycles after
//           each launch.
// Backpr. : drdy_i is sampled only in IDLE and is dropped while busy. The sbox and
//           key-expansion waits are unbounded unless the watchdog is built in.
//
// Ports   : clk, rst (async, active-low)   clock and reset
//           drdy_i / drdy_o                run start request / one-cycle done pulse
//           busy, stage, round             stage != IDLE, stage code, round 0..ROUNDS
//           sbox_drdy_i / sbox_drdy_o      sbox launch pulse / sbox done pulse
//           ke_drdy_i / ke_drdy_o          key-expansion launch pulse / done pulse
//           ke_first_round                 round == 1
//           err                            one-cycle watchdog abort pulse
// Stage codes: 0 IDLE, 1 CALC_PARAMS, 2 PREP_DATA, 3 ADD_ROUND_KEY, 4 SUB_BYTES,
//           5 SHIFT_ROWS, 6 MIX_COLS, 7 KEY_EXPAND_WAIT, 8 ADD_ROUND_KEY_LAST,
//           9 MOD_P, 10 PREP_OUTPUT.
// Option  : define CLM_CTRL_TIMEOUT_EN to build in the TIMEOUT watchdog on the
//           SUB_BYTES and KEY_EXPAND_WAIT waits. Without it, err is tied to 0.

`ifndef STAGE_BITS
`define STAGE_BITS 4
`endif
`ifndef ROUND_BITS
`define ROUND_BITS 4
`endif

module clm_round_ctrl #(
    parameter int ROUNDS       = 10,
    parameter int PARAM_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   drdy_i,
    output logic                   drdy_o,
    output logic                   busy,
    output logic [`STAGE_BITS-1:0] stage,
    output logic [`ROUND_BITS-1:0] round,
    output logic                   sbox_drdy_i,
    input  logic                   sbox_drdy_o,
    output logic                   ke_drdy_i,
    input  logic                   ke_drdy_o,
    output logic                   ke_first_round,
    output logic                   err
);

    typedef enum logic [`STAGE_BITS-1:0] {
        IDLE               = 0,
        CALC_PARAMS        = 1,
        PREP_DATA          = 2,
        ADD_ROUND_KEY      = 3,
        SUB_BYTES          = 4,
        SHIFT_ROWS         = 5,
        MIX_COLS           = 6,
        KEY_EXPAND_WAIT    = 7,
        ADD_ROUND_KEY_LAST = 8,
        MOD_P              = 9,
        PREP_OUTPUT        = 10
    } stages_t;

    localparam int RB   = `ROUND_BITS;
    localparam int CMAX = (TIMEOUT > PARAM_CYCLES) ? TIMEOUT : PARAM_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [RB-1:0] RLAST   = RB'(ROUNDS);
    localparam logic [CW-1:0] PC_LAST = CW'(PARAM_CYCLES - 1);

    stages_t       state, state_nxt;
    logic [RB-1:0] round_q, round_nxt;
    logic [CW-1:0] cnt;
    logic          sbox_flag, ke_flag;
    logic          launch, accept, counting;
    logic          sbox_done, ke_done, tmo;

    // cnt is one per-stage cycle counter. It clears on every stage change, so
    // cnt == 0 in SUB_BYTES marks the launch cycle. The same counter times
    // CALC_PARAMS and the watchdog.
    assign launch   = (state == SUB_BYTES) && (cnt == '0);
    assign counting = (state == CALC_PARAMS) || (state == SUB_BYTES) ||
                      (state == KEY_EXPAND_WAIT);

    // Done pulses count only after a launch. A pulse in IDLE, CALC_PARAMS or
    // PREP_DATA is dropped, and so is one that coincides with the launch.
    assign accept = (state != IDLE) && (state != CALC_PARAMS) &&
                    (state != PREP_DATA) && !launch;

    // In the launch cycle the flag still holds the previous round's value,
    // so the flag is masked there along with the stale pulse.
    assign sbox_done = !launch && (sbox_drdy_o || sbox_flag);
    assign ke_done   = ke_drdy_o || ke_flag;

`ifdef CLM_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
    assign tmo = ((state == SUB_BYTES) || (state == KEY_EXPAND_WAIT)) && (cnt == TO_LIM);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        round_nxt = round_q;
        case (state)
            IDLE: begin
                if (drdy_i) begin
                    state_nxt = CALC_PARAMS;
                    round_nxt = '0;
                end
            end
            CALC_PARAMS: begin
                if (cnt == PC_LAST) state_nxt = PREP_DATA;
            end
            PREP_DATA:     state_nxt = ADD_ROUND_KEY;
            ADD_ROUND_KEY: begin
                state_nxt = SUB_BYTES;
                if (round_q != RLAST) round_nxt = round_q + 1'b1;
            end
            SUB_BYTES: begin
                if (sbox_done) state_nxt = SHIFT_ROWS;
            end
            SHIFT_ROWS: begin
                state_nxt = (round_q < RLAST) ? MIX_COLS : KEY_EXPAND_WAIT;
            end
            MIX_COLS:      state_nxt = KEY_EXPAND_WAIT;
            KEY_EXPAND_WAIT: begin
                if (ke_done) state_nxt = (round_q < RLAST) ? ADD_ROUND_KEY : ADD_ROUND_KEY_LAST;
            end
            ADD_ROUND_KEY_LAST: state_nxt = MOD_P;
            MOD_P:              state_nxt = PREP_OUTPUT;
            PREP_OUTPUT: begin
                state_nxt = IDLE;
                round_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                round_nxt = '0;
            end
        endcase
        // The watchdog abort takes priority over a done that lands in the
        // same cycle.
        if (tmo) begin
            state_nxt = IDLE;
            round_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            round_q <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            round_q <= round_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (counting && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sbox_flag <= 1'b0;
            ke_flag   <= 1'b0;
        end else if ((state_nxt == IDLE) || launch) begin
            sbox_flag <= 1'b0;
            ke_flag   <= 1'b0;
        end else if (accept) begin
            if (sbox_drdy_o) sbox_flag <= 1'b1;
            if (ke_drdy_o)   ke_flag   <= 1'b1;
        end
    end

    assign stage          = state;
    assign round          = round_q;
    assign busy           = (state != IDLE);
    assign drdy_o         = (state == PREP_OUTPUT);
    assign sbox_drdy_i    = launch;
    assign ke_drdy_i      = launch;
    assign ke_first_round = (round_q == RB'(1));
    assign err            = tmo;

endmodule

// File: tb/tb_clm_round_ctrl.sv
// Purpose : self-checking bench for clm_round_ctrl. A per-cycle expected
//           stage/round trace is built from the stage durations. Responders
//           answer the DUT launch pulses after per-round random delays.
// Latency : not applicable (bench).
// Backpr. : not applicable (bench).
module tb_clm_round_ctrl;

    localparam int ROUNDS = 10;
    localparam int PCYC   = 2;
    localparam int TMO    = 64;

    localparam logic [3:0] S_IDLE = 4'd0,  S_CALC  = 4'd1, S_PREP  = 4'd2,
                           S_ARK  = 4'd3,  S_SUB   = 4'd4, S_SHIFT = 4'd5,
                           S_MIX  = 4'd6,  S_KEW   = 4'd7, S_ARKL  = 4'd8,
                           S_MODP = 4'd9,  S_OUT   = 4'd10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drdy_i = 1'b0;
    logic       sbox_drdy_o = 1'b0;
    logic       ke_drdy_o = 1'b0;
    logic       drdy_o, busy, sbox_drdy_i, ke_drdy_i, ke_first_round, err;
    logic [3:0] stage, round;

    clm_round_ctrl #(.ROUNDS(ROUNDS), .PARAM_CYCLES(PCYC), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .drdy_i         (drdy_i),
        .drdy_o         (drdy_o),
        .busy           (busy),
        .stage          (stage),
        .round          (round),
        .sbox_drdy_i    (sbox_drdy_i),
        .sbox_drdy_o    (sbox_drdy_o),
        .ke_drdy_i      (ke_drdy_i),
        .ke_drdy_o      (ke_drdy_o),
        .ke_first_round (ke_first_round),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] rnd;
        logic       done;
        logic       lch;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   ds[1:ROUNDS];
    int   dk[1:ROUNDS];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle(input exp_t e);
        check("stage",          32'(stage),          32'(e.st));
        check("round",          32'(round),          32'(e.rnd));
        check("drdy_o",         32'(drdy_o),         32'(e.done));
        check("busy",           32'(busy),           32'(e.st != S_IDLE));
        check("sbox_launch",    32'(sbox_drdy_i),    32'(e.lch));
        check("ke_launch",      32'(ke_drdy_i),      32'(e.lch));
        check("ke_first_round", 32'(ke_first_round), 32'(e.rnd == 4'd1));
        check("err",            32'(err),            32'(e.err));
    endtask

    task automatic push(input logic [3:0] st, input int rnd, input int n, input bit lch, input bit done);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.st   = st;
            e.rnd  = 4'(rnd);
            e.done = done;
            e.lch  = lch && (k == 0);
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Trace index 0 is the IDLE cycle where drdy_i is sampled. Each later stage
    // holds for its nominal length. SUB_BYTES holds until the sbox answer,
    // KEY_EXPAND_WAIT until the ke answer (at least one cycle).
    task automatic build();
        int   l, k, n;
        exp_t e;
        exp_q.delete();
        push(S_IDLE, 0, 1, 0, 0);
        push(S_CALC, 0, PCYC, 0, 0);
        push(S_PREP, 0, 1, 0, 0);
        for (int r = 1; r <= ROUNDS; r++) begin
            push(S_ARK, r - 1, 1, 0, 0);
            l = exp_q.size();
            if (ds[r] < 0) begin
                push(S_SUB, r, TMO + 1, 1, 0);
                e = exp_q.pop_back();
                e.err = 1'b1;
                exp_q.push_back(e);
                return;
            end
            push(S_SUB, r, ds[r] + 1, 1, 0);
            push(S_SHIFT, r, 1, 0, 0);
            if (r < ROUNDS) push(S_MIX, r, 1, 0, 0);
            k = exp_q.size();
            n = (l + dk[r] <= k) ? 1 : (l + dk[r] - k + 1);
            push(S_KEW, r, n, 0, 0);
        end
        push(S_ARKL, ROUNDS, 1, 0, 0);
        push(S_MODP, ROUNDS, 1, 0, 0);
        push(S_OUT,  ROUNDS, 1, 0, 1);
    endtask

    task automatic set_delays(input int s, input int k);
        for (int r = 1; r <= ROUNDS; r++) begin
            ds[r] = s;
            dk[r] = k;
        end
    endtask

    task automatic idle(input int n);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_cycle(e);
            drdy_i      = 1'b0;
            sbox_drdy_o = 1'($urandom_range(0, 1));
            ke_drdy_o   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run(input bit hold, input bit spur, input bit stale, input int abort_at);
        int lc = 0, sb_at = -1, ke_at = -1, n_ke = 0, n_done = 0;
        bit tmo_run;
        build();
        tmo_run = exp_q[exp_q.size() - 1].err;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_cycle(exp_q[i]);
            if (ke_drdy_i) n_ke++;
            if (drdy_o)    n_done++;
            if (sbox_drdy_i && lc < ROUNDS) begin
                lc++;
                sb_at = (ds[lc] < 0) ? -1 : i + ds[lc];
                ke_at = i + dk[lc];
            end
            if (i == abort_at) begin
                rst = 1'b0;
                #1;
                check("rst_stage", 32'(stage),       32'(S_IDLE));
                check("rst_round", 32'(round),       32'd0);
                check("rst_busy",  32'(busy),        32'd0);
                check("rst_drdy",  32'(drdy_o),      32'd0);
                check("rst_sbox",  32'(sbox_drdy_i), 32'd0);
                check("rst_ke",    32'(ke_drdy_i),   32'd0);
                check("rst_err",   32'(err),         32'd0);
                drdy_i      = 1'b0;
                sbox_drdy_o = 1'b0;
                ke_drdy_o   = 1'b0;
                @(negedge clk);
                check("rst_hold_stage", 32'(stage), 32'(S_IDLE));
                rst = 1'b1;
                return;
            end
            drdy_i      = (i == 0) || hold || (spur && (i == 20 || i == 40));
            sbox_drdy_o = (i == sb_at) || (spur && i == 0) || (stale && sbox_drdy_i);
            ke_drdy_o   = (i == ke_at) || (spur && i == 1) || (stale && ke_drdy_i);
        end
        if (tmo_run) begin
            check("tmo_done_pulses", 32'(n_done), 32'd0);
        end else begin
            check("ke_launches", 32'(n_ke), 32'(ROUNDS));
            check("done_pulses", 32'(n_done), 32'd1);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        check_cycle('0);
        @(negedge clk);
        check_cycle('0);
        rst = 1'b1;
        idle(2);

        // Nominal: sbox 3, ke 5 cycles after launch.
        set_delays(3, 5);
        run(0, 0, 0, -1);
        idle(3);
        // Ke answers before sbox; KEY_EXPAND_WAIT lasts one cycle.
        set_delays(6, 2);
        run(0, 0, 0, -1);
        idle(2);
        // Spurious drdy_i while busy and done pulses in IDLE/CALC_PARAMS.
        set_delays(3, 5);
        run(0, 1, 0, -1);
        idle(2);
        // Stale done pulses coinciding with each launch.
        set_delays(2, 4);
        run(0, 0, 1, -1);
        idle(2);
        // Async reset in round 4 mid-SUB_BYTES, then a clean run.
        set_delays(3, 5);
        run(0, 0, 0, 30);
        idle(2);
        run(0, 0, 0, -1);
        // drdy_i held high restarts on the cycle after returning to IDLE.
        run(1, 0, 0, -1);
        run(0, 0, 0, -1);
        idle(2);
`ifdef CLM_CTRL_TIMEOUT_EN
        set_delays(3, 5);
        ds[2] = -1;
        run(0, 0, 0, -1);
        idle(2);
        set_delays(3, 5);
        run(0, 0, 0, -1);
        idle(2);
`endif
        for (int n = 0; n < 8; n++) begin
            bit h;
            for (int r = 1; r <= ROUNDS; r++) begin
                ds[r] = int'($urandom_range(1, 8));
                dk[r] = int'($urandom_range(1, 12));
            end
            h = 1'($urandom_range(0, 1));
            run(h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            if (!h) idle(int'($urandom_range(1, 3)));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d obs=running exp=finished", cyc);
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/clm_round_ctrl.md
Name: clm_round_ctrl

Overview:
- Top-level sequencer for the CLM masked-AES core; drives the `stages_t` stage code and the round counter that the shared datapath decodes.
- Launches and collects the sbox and key-expansion submodules through their `drdy_i`/`drdy_o` handshakes.
- Reports completion to the `clm_inouts_if` level.
- Holds no cipher data; control only.

Parameters:
- ROUNDS, 10: number of AES rounds; the last round omits MIX_COLS.
- PARAM_CYCLES, 2: cycles spent in CALC_PARAMS (P-derived matrix settle time); must be >= 1.
- TIMEOUT, 64: watchdog limit in cycles, used only with CLM_CTRL_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- drdy_i  input  1  start request; sampled only in IDLE.
- drdy_o  output  1  one-cycle done pulse, asserted in PREP_OUTPUT.
- busy  output  1  high whenever stage != IDLE.
- stage  output  `STAGE_BITS  current stage (stages_t encoding).
- round  output  `ROUND_BITS  current round, 0..ROUNDS.
- sbox_drdy_i  output  1  one-cycle sbox launch pulse.
- sbox_drdy_o  input  1  sbox done pulse.
- ke_drdy_i  output  1  one-cycle key-expansion launch pulse.
- ke_drdy_o  input  1  key-expansion done pulse.
- ke_first_round  output  1  equals (round == 1).
- err  output  1  one-cycle watchdog abort pulse.

Behaviour:
- Reset (async, rst=0):
  - stage=IDLE, round=0.
  - drdy_o, busy, sbox_drdy_i, ke_drdy_i, err all 0.
  - Done flags and counters cleared.
  - Applies at any point, including mid-encryption; no drdy_o is produced for an aborted run.
- IDLE: drdy_i=1 -> CALC_PARAMS, round=0.
- CALC_PARAMS: stays exactly PARAM_CYCLES cycles, then -> PREP_DATA.
- PREP_DATA: 1 cycle -> ADD_ROUND_KEY.
- ADD_ROUND_KEY: 1 cycle. round <= round+1 -> SUB_BYTES.
- SUB_BYTES:
  - First cycle of the state: sbox_drdy_i=1 and ke_drdy_i=1, both for exactly one cycle. Both done flags are cleared that cycle.
  - A done pulse that coincides with its launch pulse is treated as stale and ignored.
  - Exits in the cycle sbox_drdy_o=1 or sbox_flag=1 -> SHIFT_ROWS.
- Done flags: ke_drdy_o pulses arriving at any cycle after launch set sticky ke_flag until the next launch. sbox_drdy_o sets sbox_flag the same way.
- SHIFT_ROWS: 1 cycle.
  - -> MIX_COLS if round < ROUNDS.
  - -> KEY_EXPAND_WAIT if round == ROUNDS.
- MIX_COLS: 1 cycle -> KEY_EXPAND_WAIT.
- KEY_EXPAND_WAIT: minimum 1 cycle; exits in the cycle ke_drdy_o=1 or ke_flag=1.
  - -> ADD_ROUND_KEY if round < ROUNDS.
  - -> ADD_ROUND_KEY_LAST otherwise.
- ADD_ROUND_KEY_LAST: 1 cycle -> MOD_P.
- MOD_P: 1 cycle -> PREP_OUTPUT.
- PREP_OUTPUT: drdy_o=1 for this single cycle -> IDLE; round returns to 0.
- drdy_i while busy: ignored, not queued. drdy_i held high in IDLE starts a new run on the cycle after PREP_OUTPUT returns to IDLE.
- Done pulses received in IDLE, CALC_PARAMS or PREP_DATA: ignored, no flag set.
- round never exceeds ROUNDS; no wrap.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path.

Optional Feature:
- Macro: CLM_CTRL_TIMEOUT_EN.
- Enabled:
  - A cycle counter runs while in SUB_BYTES or KEY_EXPAND_WAIT and clears on every state change.
  - When it reaches TIMEOUT without the awaited done: err=1 for one cycle, next stage = IDLE, round=0, flags cleared, no drdy_o.
- Disabled: err tied 0; waits are unbounded.

Test Plan:
- Nominal run, PARAM_CYCLES=2, sbox done 3 cycles after launch, ke done 5 cycles after launch, drdy_i at cycle 0:
  - SUB_BYTES entered at cycles 5, 13, ..., 77.
  - MIX_COLS absent in round 10.
  - drdy_o=1 at cycle 85 only; stage sequence matches Behaviour.
- ke done before sbox done (ke 2 cycles, sbox 6 cycles after launch) -> ke_flag latched; KEY_EXPAND_WAIT lasts exactly 1 cycle each round.
- Early and spurious pulses:
  - drdy_i pulsed at cycles 20 and 40 -> ignored; exactly one drdy_o.
  - sbox_drdy_o pulsed in IDLE -> no flag; the first round still waits for the real done.
- Async reset: rst=0 asserted at cycle 30 (round 4, mid-SUB_BYTES) -> stage=IDLE, round=0, busy=0 immediately without a clock edge. A new drdy_i then completes normally.
- ke_first_round: high only while round==1 (cycles 5..12 in the nominal run); ke_drdy_i pulses exactly 10 times per run.
- With CLM_CTRL_TIMEOUT_EN, TIMEOUT=64, sbox never responds in round 2 -> err pulse exactly 64 cycles after SUB_BYTES entry; stage=IDLE next cycle; drdy_o never asserted.
